// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with load, wrap/saturate and tc/wrap flags
module updown_counter_param #(
  parameter int WIDTH    = 8,
  parameter int MOD      = 256,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == L_MAX);
  assign w_at_zero = (r_q == '0);

  // Bound checks use explicit compares so MOD == 2**WIDTH still flags its wrap.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (load) begin
      w_q_next = (load_val > L_MAX) ? L_MAX : load_val;
    end else if (en) begin
      if (!mode) begin
        if (!w_at_max) begin
          w_q_next = r_q + WIDTH'(1);
        end else if (!SATURATE) begin
          w_q_next    = '0;
          w_wrap_next = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_q_next = r_q - WIDTH'(1);
        end else if (!SATURATE) begin
          w_q_next    = L_MAX;
          w_wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign tc   = mode ? w_at_zero : w_at_max;

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - scoreboard bench for updown_counter_param across several configurations
module tb_updown_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] en_v, mode_v, load_v;
  logic [7:0] lv_v [5];

  logic [3:0] q_a, q_b, q_lo, q_hi;
  logic [7:0] q_c;
  logic [1:0] q_e;
  logic tc_a, tc_b, tc_c, tc_lo, tc_hi, tc_e;
  logic wrap_a, wrap_b, wrap_c, wrap_lo, wrap_hi, wrap_e;

  // sel 0: 4b/10 wrap, 1: 4b/10 saturate, 2: 8b/256 wrap, 3: cascaded {hi,lo}, 4: 2b/2 wrap
  updown_counter_param #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .mode(mode_v[0]), .load(load_v[0]),
    .load_val(lv_v[0][3:0]), .q(q_a), .tc(tc_a), .wrap(wrap_a));
  updown_counter_param #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .mode(mode_v[1]), .load(load_v[1]),
    .load_val(lv_v[1][3:0]), .q(q_b), .tc(tc_b), .wrap(wrap_b));
  updown_counter_param #(.WIDTH(8), .MOD(256), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .mode(mode_v[2]), .load(load_v[2]),
    .load_val(lv_v[2]), .q(q_c), .tc(tc_c), .wrap(wrap_c));
  updown_counter_param #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en_v[3]), .mode(mode_v[3]), .load(load_v[3]),
    .load_val(lv_v[3][3:0]), .q(q_lo), .tc(tc_lo), .wrap(wrap_lo));
  updown_counter_param #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(wrap_lo), .mode(mode_v[3]), .load(load_v[3]),
    .load_val(lv_v[3][7:4]), .q(q_hi), .tc(tc_hi), .wrap(wrap_hi));
  updown_counter_param #(.WIDTH(2), .MOD(2), .SATURATE(1'b0)) u_e (
    .clk(clk), .rst_n(rst_n), .en(en_v[4]), .mode(mode_v[4]), .load(load_v[4]),
    .load_val(lv_v[4][1:0]), .q(q_e), .tc(tc_e), .wrap(wrap_e));

  logic [7:0] aq [5];
  logic       aw [5];
  logic       at [5];
  assign aq[0] = {4'h0, q_a};   assign aw[0] = wrap_a;  assign at[0] = tc_a;
  assign aq[1] = {4'h0, q_b};   assign aw[1] = wrap_b;  assign at[1] = tc_b;
  assign aq[2] = q_c;           assign aw[2] = wrap_c;  assign at[2] = tc_c;
  assign aq[3] = {q_hi, q_lo};  assign aw[3] = wrap_hi; assign at[3] = tc_hi | tc_lo & 1'b0;
  assign aq[4] = {6'h0, q_e};   assign aw[4] = wrap_e;  assign at[4] = tc_e;

  typedef struct {
    int         sel;
    int         id;
    logic [7:0] q;
    logic       w;
    logic       t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   vec_id   = 0;

  task automatic check(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec %0d: got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  task automatic step(input int sel, input bit ld, input bit en, input bit md, input logic [7:0] lv,
                      input bit chk, input logic [7:0] q, input bit w, input bit t);
    exp_t e;
    @(negedge clk);
    en_v        = '0;
    load_v      = '0;
    en_v[sel]   = en;
    load_v[sel] = ld;
    mode_v[sel] = md;
    lv_v[sel]   = lv;
    vec_id++;
    if (chk) begin
      e.sel = sel; e.id = vec_id; e.q = q; e.w = w; e.t = t;
      sb.push_back(e);
    end
  endtask

  task automatic v(input int sel, input bit ld, input bit en, input bit md, input logic [7:0] lv,
                   input logic [7:0] q, input bit w, input bit t);
    step(sel, ld, en, md, lv, 1'b1, q, w, t);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q", e.id, aq[e.sel], e.q);
        check("wrap", e.id, {7'h0, aw[e.sel]}, {7'h0, e.w});
        check("tc", e.id, {7'h0, at[e.sel]}, {7'h0, e.t});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n  = 1'b0;
    en_v   = '0;
    mode_v = '0;
    load_v = '0;
    for (int i = 0; i < 5; i++) lv_v[i] = 8'h00;
    #2;
    for (int i = 0; i < 5; i++) begin
      check("reset_q", i, aq[i], 8'h00);
      check("reset_wrap", i, {7'h0, aw[i]}, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // counting into a wrap, then asynchronous reset during the wrap pulse
    for (int i = 1; i <= 10; i++)
      v(0, 0, 1, 0, 8'h00, 8'(i % 10), i == 10, i == 9);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", 0, aq[0], 8'h00);
    check("async_rst_wrap", 0, {7'h0, aw[0]}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_q", 0, aq[0], 8'h00);
    en_v   = '0;
    load_v = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // reset release then wrap-up: 1..9,0,1,2
    for (int i = 1; i <= 12; i++)
      v(0, 0, 1, 0, 8'h00, 8'(i % 10), i == 10, (i % 10) == 9);

    // down wrap: 2,1,0,9,8
    v(0, 1, 1, 1, 8'h02, 8'h02, 0, 0);
    v(0, 0, 1, 1, 8'h00, 8'h01, 0, 0);
    v(0, 0, 1, 1, 8'h00, 8'h00, 0, 1);
    v(0, 0, 1, 1, 8'h00, 8'h09, 1, 0);
    v(0, 0, 1, 1, 8'h00, 8'h08, 0, 0);

    // load priority and clamp
    v(0, 1, 1, 0, 8'h05, 8'h05, 0, 0);
    v(0, 1, 1, 0, 8'h0D, 8'h09, 0, 1);
    v(0, 1, 1, 1, 8'h0F, 8'h09, 0, 0);
    v(0, 1, 1, 0, 8'h00, 8'h00, 0, 0);

    // saturate at both bounds
    v(1, 1, 0, 0, 8'h08, 8'h08, 0, 0);
    v(1, 0, 1, 0, 8'h00, 8'h09, 0, 1);
    v(1, 0, 1, 0, 8'h00, 8'h09, 0, 1);
    v(1, 0, 1, 0, 8'h00, 8'h09, 0, 1);
    v(1, 1, 0, 1, 8'h01, 8'h01, 0, 0);
    v(1, 0, 1, 1, 8'h00, 8'h00, 0, 1);
    v(1, 0, 1, 1, 8'h00, 8'h00, 0, 1);
    v(1, 0, 1, 1, 8'h00, 8'h00, 0, 1);

    // enable toggling and direction reversal at 0x10
    v(2, 1, 0, 0, 8'h0E, 8'h0E, 0, 0);
    v(2, 0, 1, 0, 8'h00, 8'h0F, 0, 0);
    v(2, 0, 0, 0, 8'h00, 8'h0F, 0, 0);
    v(2, 0, 1, 0, 8'h00, 8'h10, 0, 0);
    v(2, 0, 0, 1, 8'h00, 8'h10, 0, 0);
    v(2, 0, 1, 1, 8'h00, 8'h0F, 0, 0);
    v(2, 0, 0, 1, 8'h00, 8'h0F, 0, 0);
    v(2, 0, 1, 1, 8'h00, 8'h0E, 0, 0);
    v(2, 1, 0, 0, 8'hFF, 8'hFF, 0, 1);
    @(posedge clk);
    #2;
    mode_v[2] = 1'b1;
    #1;
    check("tc_mode_down", vec_id, {7'h0, tc_c}, 8'h00);
    mode_v[2] = 1'b0;
    #1;
    check("tc_mode_up", vec_id, {7'h0, tc_c}, 8'h01);
    v(2, 0, 1, 0, 8'h00, 8'h00, 1, 0);
    v(2, 0, 1, 0, 8'h00, 8'h01, 0, 0);
    v(2, 1, 0, 1, 8'h00, 8'h00, 0, 1);
    v(2, 0, 1, 1, 8'h00, 8'hFF, 1, 0);

    // smallest modulus, wraps in both directions and load clamp
    v(4, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    v(4, 0, 1, 0, 8'h00, 8'h01, 0, 1);
    v(4, 0, 1, 0, 8'h00, 8'h00, 1, 0);
    v(4, 0, 1, 0, 8'h00, 8'h01, 0, 1);
    v(4, 0, 1, 1, 8'h00, 8'h00, 0, 1);
    v(4, 0, 1, 1, 8'h00, 8'h01, 1, 0);
    v(4, 1, 1, 0, 8'h03, 8'h01, 0, 1);

    // two-stage decade cascade, 25 edges from zero
    v(3, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 1; i <= 25; i++)
      step(3, 0, 1, 0, 8'h00, i == 25, 8'h25, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    check("sb_drain", 0, 8'(sb.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised synchronous up/down counter. It is the next generation of the team's 3-bit up/down counter, with these additions:
- configurable width and modulus
- count enable
- synchronous parallel load
- selectable wrap or saturate behaviour at the count bounds
- terminal-count and wrap-event flags

It is used as a general-purpose timing and sequencing counter in lab datapaths. It can also be cascaded through the wrap output.

Parameters:
WIDTH, 8, counter width in bits; WIDTH >= 2.
MOD, 256, count range is 0..MOD-1; legal range 2 <= MOD <= 2**WIDTH.
SATURATE, 0, 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  count enable.
mode  input  1  direction: 0 = up, 1 = down.
load  input  1  synchronous parallel load; has priority over en.
load_val  input  WIDTH  value loaded when load = 1.
q  output  WIDTH  registered count value.
tc  output  1  terminal count (combinational from q and mode).
wrap  output  1  registered one-cycle pulse on wrap-around.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- rst_n low:
  - q = 0 and wrap = 0 immediately, without waiting for a clock edge.
  - State holds at these values while rst_n stays low.
  - The first update happens on the first rising edge of clk after rst_n goes high.
- Reset asserted mid-count: q is forced to 0 at once. A wrap pulse in progress is cleared.
- Priority at each rising edge of clk: load, then en, then hold.
- Load (load = 1):
  - If load_val < MOD, q <= load_val.
  - If load_val >= MOD, q <= MOD-1 (clamped).
  - wrap <= 0. The values of en and mode are ignored.
- Up count (en = 1, mode = 0):
  - If q < MOD-1: q <= q+1, wrap <= 0.
  - If q == MOD-1 and SATURATE = 0: q <= 0, wrap <= 1.
  - If q == MOD-1 and SATURATE = 1: q holds, wrap <= 0.
- Down count (en = 1, mode = 1):
  - If q > 0: q <= q-1, wrap <= 0.
  - If q == 0 and SATURATE = 0: q <= MOD-1, wrap <= 1.
  - If q == 0 and SATURATE = 1: q holds at 0, wrap <= 0.
- Hold (en = 0, load = 0): q holds, wrap <= 0.
- Latency:
  - q changes one edge after the qualifying inputs are sampled.
  - wrap is high in exactly the cycle in which q shows the wrapped value.
  - wrap is never high for two consecutive cycles unless a wrap occurs on each of those edges. Example: MOD = 2, counting continuously.
- tc:
  - tc = (mode == 0 && q == MOD-1) || (mode == 1 && q == 0).
  - tc is purely combinational and independent of en.
  - A change on mode changes tc within the same cycle.
- Direction change: a change on mode takes effect at the next edge. No dead cycle and no skipped value.
- Arithmetic:
  - All arithmetic is unsigned and modulo-MOD as defined above.
  - q never holds a value >= MOD, including after a load.
  - When MOD = 2**WIDTH, wrap-around is the natural binary overflow, but wrap must still pulse.
- Cascading: the wrap of a lower stage may drive the en of a higher stage. Both stages must use the same mode.
- No X propagation: every output is defined from the moment reset is asserted.

Test Plan:
1. Reset and wrap-up (WIDTH=4, MOD=10, SATURATE=0): assert rst_n low mid-count, then release; en=1, mode=0 for 12 edges. Required: q goes to 0 asynchronously. After release, q = 1,2,...,9,0,1,2. wrap=1 only in the cycle with q=0 following q=9. tc=1 while q=9.
2. Down wrap (WIDTH=4, MOD=10, SATURATE=0): load load_val=2, then mode=1 for 4 edges. Required: q = 2,1,0,9,8. wrap=1 only with the first q=9. tc=1 while q=0.
3. Saturate (WIDTH=4, MOD=10, SATURATE=1): from q=8, count up for 3 edges; then count down from 1 for 3 edges. Required: q = 9,9,9, then 0,0,0. wrap stays 0 throughout.
4. Load priority and clamp (WIDTH=4, MOD=10): load=1, en=1, load_val=5; then load_val=13. Required: q=5 (no increment that cycle); then q=9 (clamped); wrap=0 on both.
5. Enable and direction toggle (WIDTH=8, MOD=256, SATURATE=0): en toggles every other cycle; mode flips at q=0x10; then count up from q=0xFF. Required:
   - q holds on en=0 cycles.
   - Reversal gives q = 0x10 -> 0x0F with no skipped value.
   - tc changes in the same cycle as mode.
   - 0xFF -> 0x00 with wrap=1.
6. Cascade: two instances (MOD=10 each), the wrap of the low stage drives the en of the high stage, run 25 edges. Required: {hi,lo} reads 2,5 decimal.
